// File: rtl/lcd_phy_param.sv
// lcd_phy_param: HD44780-class LCD pin driver with 4/8-bit bus and parametrised timing.
// Define LCD_PWRUP_WAIT_EN to insert a T_PWRUP_CYC power-up wait ahead of the init sequence.
module lcd_phy_param #(
   parameter int BUS_WIDTH   = 4,
   parameter int CNT_W       = 20,
   parameter int T_E_CYC     = 24,
   parameter int T_GAP_CYC   = 100,
   parameter int T_CMD_CYC   = 4000,
   parameter int T_LONG_CYC  = 82000,
   parameter int T_INIT1_CYC = 250000,
   parameter int T_INIT2_CYC = 10000,
   parameter int T_PWRUP_CYC = 750000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 do_init,
   input  logic                 do_send_data,
   input  logic [7:0]           data_to_send,
   input  logic                 lcdrs_in,
   output logic                 busy,
   output logic                 ready,
   output logic                 init_done,
   output logic                 send_data_done,
   output logic                 lcde,
   output logic                 lcdrs,
   output logic                 lcdrw,
   output logic [BUS_WIDTH-1:0] lcddat
);
   typedef enum logic [2:0] {IDLE, PWRUP, SETUP, STROBE, GAP, WAIT} state_t;
   localparam bit W4 = (BUS_WIDTH == 4);
   localparam logic [2:0] LAST = W4 ? 3'd3 : 3'd2;
   if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
      $error("lcd_phy_param: BUS_WIDTH must be 4 or 8");
   end
   state_t state, nxt;
   logic [CNT_W-1:0] cnt, tlen, wlen;
   logic [2:0] step, nxt_step;
   logic [7:0] byte_l, nxt_byte;
   logic [BUS_WIDTH-1:0] dat;
   logic rs_l, nxt_rs, init_l, nxt_init, lo, nxt_lo;
   logic t_end, long_w, init_fin, send_fin;
   assign lcdrw = 1'b0;
   // clear/home commands need the long settle time
   assign long_w = !rs_l && byte_l[7:2] == 6'd0 && byte_l[1:0] != 2'd0;
   assign wlen = init_l ? (step == 3'd0 ? CNT_W'(T_INIT1_CYC) :
                           step == 3'd1 ? CNT_W'(T_INIT2_CYC) : CNT_W'(T_CMD_CYC)) :
                 long_w ? CNT_W'(T_LONG_CYC) : CNT_W'(T_CMD_CYC);
   assign tlen = state == STROBE ? CNT_W'(T_E_CYC) :
                 state == GAP    ? CNT_W'(T_GAP_CYC) :
                 state == PWRUP  ? CNT_W'(T_PWRUP_CYC) :
                 state == SETUP  ? CNT_W'(1) : wlen;
   assign t_end = cnt == tlen - CNT_W'(1);
   always_comb begin
      nxt      = state;
      nxt_step = step;
      nxt_lo   = lo;
      nxt_init = init_l;
      nxt_byte = byte_l;
      nxt_rs   = rs_l;
      init_fin = 1'b0;
      send_fin = 1'b0;
      case (state)
         IDLE:
            if (do_init || do_send_data) begin
               nxt_init = do_init;
               nxt_step = 3'd0;
               nxt_lo   = 1'b0;
               nxt_byte = data_to_send;
               nxt_rs   = lcdrs_in;
`ifdef LCD_PWRUP_WAIT_EN
               nxt      = do_init ? PWRUP : SETUP;
`else
               nxt      = SETUP;
`endif
            end
         PWRUP:  if (t_end) nxt = SETUP;
         SETUP:  nxt = STROBE;
         STROBE: if (t_end) nxt = (!init_l && W4 && !lo) ? GAP : WAIT;
         GAP:
            if (t_end) begin
               nxt    = SETUP;
               nxt_lo = 1'b1;
            end
         WAIT:
            if (t_end) begin
               if (init_l && step != LAST) begin
                  nxt      = SETUP;
                  nxt_step = step + 3'd1;
               end else begin
                  nxt      = IDLE;
                  init_fin = init_l;
                  send_fin = !init_l;
               end
            end
         default: nxt = IDLE;
      endcase
   end
   // pin value for the SETUP being entered, from the next-cycle context
   assign dat = nxt_init ? BUS_WIDTH'(W4 ? (nxt_step == 3'd3 ? 8'h02 : 8'h03) : 8'h30) :
                BUS_WIDTH'(W4 ? {4'h0, nxt_lo ? nxt_byte[3:0] : nxt_byte[7:4]} : nxt_byte);
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         step           <= 3'd0;
         byte_l         <= 8'd0;
         rs_l           <= 1'b0;
         init_l         <= 1'b0;
         lo             <= 1'b0;
         busy           <= 1'b0;
         ready          <= 1'b0;
         init_done      <= 1'b0;
         send_data_done <= 1'b0;
         lcde           <= 1'b0;
         lcdrs          <= 1'b0;
         lcddat         <= '0;
      end else begin
         state          <= nxt;
         cnt            <= (nxt != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
         step           <= nxt_step;
         byte_l         <= nxt_byte;
         rs_l           <= nxt_rs;
         init_l         <= nxt_init;
         lo             <= nxt_lo;
         busy           <= nxt != IDLE;
         ready          <= init_fin | (ready & ~(state == IDLE & do_init));
         init_done      <= init_fin;
         send_data_done <= send_fin;
         lcde           <= nxt == STROBE;
         lcdrs          <= nxt == SETUP ? (!nxt_init && nxt_rs) : nxt == PWRUP ? 1'b0 : lcdrs;
         lcddat         <= nxt == SETUP ? dat : nxt == PWRUP ? '0 : lcddat;
      end
   end
endmodule

// File: tb/tb_lcd_phy_param.sv
// tb_lcd_phy_param: checks strobe data, widths and spacing of the LCD driver against
// transfer lists derived from the protocol rules, for a 4-bit and an 8-bit instance.
module tb_lcd_phy_param;
   localparam int TE = 4, TG = 3, TC = 10, TL = 30, TI1 = 20, TI2 = 8, TP = 50;
`ifdef LCD_PWRUP_WAIT_EN
   localparam int PW = TP;
`else
   localparam int PW = 0;
`endif
   logic clk = 0, reset = 0, di4 = 0, ds4 = 0, di8 = 0, ds8 = 0, rsin = 0, sel = 0;
   logic [7:0] data = 0;
   logic busy4, ready4, idn4, sdn4, e4, rs4, rw4;
   logic busy8, ready8, idn8, sdn8, e8, rs8, rw8;
   logic [3:0] dat4;
   logic [7:0] dat8;
   int passed = 0, total = 0;
   always #5 clk = ~clk;
   lcd_phy_param #(.BUS_WIDTH(4), .T_E_CYC(TE), .T_GAP_CYC(TG), .T_CMD_CYC(TC), .T_LONG_CYC(TL),
      .T_INIT1_CYC(TI1), .T_INIT2_CYC(TI2), .T_PWRUP_CYC(TP)) u4 (
      .clk(clk), .reset(reset), .do_init(di4), .do_send_data(ds4), .data_to_send(data),
      .lcdrs_in(rsin), .busy(busy4), .ready(ready4), .init_done(idn4), .send_data_done(sdn4),
      .lcde(e4), .lcdrs(rs4), .lcdrw(rw4), .lcddat(dat4));
   lcd_phy_param #(.BUS_WIDTH(8), .T_E_CYC(TE), .T_GAP_CYC(TG), .T_CMD_CYC(TC), .T_LONG_CYC(TL),
      .T_INIT1_CYC(TI1), .T_INIT2_CYC(TI2), .T_PWRUP_CYC(TP)) u8 (
      .clk(clk), .reset(reset), .do_init(di8), .do_send_data(ds8), .data_to_send(data),
      .lcdrs_in(rsin), .busy(busy8), .ready(ready8), .init_done(idn8), .send_data_done(sdn8),
      .lcde(e8), .lcdrs(rs8), .lcdrw(rw8), .lcddat(dat8));
   wire       e_s     = sel ? e8 : e4;
   wire [7:0] dat_s   = sel ? dat8 : {4'h0, dat4};
   wire       rs_s    = sel ? rs8 : rs4;
   wire       busy_s  = sel ? busy8 : busy4;
   wire       ready_s = sel ? ready8 : ready4;
   wire       idn_s   = sel ? idn8 : idn4;
   wire       sdn_s   = sel ? sdn8 : sdn4;
   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask
   // one transaction; mid>1 pulses do_send_data at that sample while busy
   task automatic run(input bit w8, input bit ini, input bit both, input logic [7:0] b,
                      input bit r, input int mid);
      int ed[$], ea[$], rises[$], falls[$], dats[$], rss[$];
      int n, done_n, rs_bad, unstable, other, cur, wt, last, er, nxt_edge;
      bit pe;
      sel = w8; data = b; rsin = r;
      er = ini ? 0 : int'(r);
      wt = (!r && b >= 8'd1 && b <= 8'd3) ? TL : TC;
      if (ini && w8) begin ed = '{'h30, 'h30, 'h30}; ea = '{TI1, TI2, TC}; end
      else if (ini) begin ed = '{3, 3, 3, 2}; ea = '{TI1, TI2, TC, TC}; end
      else if (w8) begin ed = '{int'(b)}; ea = '{wt}; end
      else begin ed = '{int'(b >> 4), int'(b & 8'h0f)}; ea = '{TG, wt}; end
      @(negedge clk);
      if (w8) begin di8 = ini; ds8 = !ini || both; end
      else begin di4 = ini; ds4 = !ini || both; end
      n = 0; done_n = 0; rs_bad = 0; unstable = 0; other = 0; cur = 0; pe = 0;
      while (done_n == 0 && n < 3000) begin
         @(negedge clk);
         n++;
         if (n == 1) begin di4 = 0; ds4 = 0; di8 = 0; ds8 = 0; end
         if (mid > 1 && n == mid) begin if (w8) ds8 = 1; else ds4 = 1; end
         if (mid > 1 && n == mid + 1) begin ds8 = 0; ds4 = 0; end
         if (e_s && !pe) begin
            rises.push_back(n); dats.push_back(int'(dat_s)); rss.push_back(int'(rs_s));
            cur = int'(dat_s);
         end
         if (e_s && int'(dat_s) != cur) unstable++;
         if (!e_s && pe) falls.push_back(n);
         pe = e_s;
         if (n == 1) begin
            chk("busy_rise", int'(busy_s), 1);
            if (ini) chk("ready_clr", int'(ready_s), 0);
         end
         if (!ini && n >= 2 && rs_s != r) rs_bad++;
         if (ini ? sdn_s : idn_s) other++;
         if (ini ? idn_s : sdn_s) done_n = n;
      end
      chk("done_seen", int'(done_n != 0), 1);
      chk("busy_at_done", int'(busy_s), 0);
      if (ini) chk("ready_at_done", int'(ready_s), 1);
      chk("n_strobes", rises.size(), ed.size());
      chk("n_falls", falls.size(), ed.size());
      if (rises.size() > 0) chk("first_rise", rises[0], 2 + (ini ? PW : 0));
      last = ed.size() - 1;
      for (int i = 0; i < ed.size() && i < rises.size() && i < falls.size(); i++) begin
         chk("strobe_data", dats[i], ed[i]);
         chk("strobe_rs", rss[i], er);
         chk("strobe_width", falls[i] - rises[i], TE);
         nxt_edge = (i == last) ? done_n : (i + 1 < rises.size() ? rises[i + 1] : -1);
         chk("after_strobe", nxt_edge - falls[i], ea[i] + (i == last ? 0 : 1));
      end
      chk("data_stable", unstable, 0);
      chk("rs_held", rs_bad, 0);
      chk("no_other_done", other, 0);
      @(negedge clk);
      chk("done_pulse", int'(ini ? idn_s : sdn_s), 0);
      chk("busy_idle", int'(busy_s), 0);
   endtask
   initial begin
      int n, k;
      bit pe, w, r;
      logic [7:0] b;
      repeat (3) @(negedge clk);
      chk("rst_lcde", int'(e4 | e8), 0);
      chk("rst_dat", int'(dat4) + int'(dat8), 0);
      chk("rst_rs", int'(rs4 | rs8), 0);
      chk("rst_busy", int'(busy4 | busy8), 0);
      chk("rst_ready", int'(ready4 | ready8), 0);
      chk("rst_done", int'(idn4 | idn8 | sdn4 | sdn8), 0);
      chk("lcdrw", int'(rw4 | rw8), 0);
      reset = 1;
      @(negedge clk);
      run(0, 1, 0, 8'h00, 0, 0);
      run(0, 0, 0, 8'h48, 1, 0);
      run(1, 0, 0, 8'h01, 0, 0);
      run(1, 0, 0, 8'h01, 1, 0);
      run(1, 1, 1, 8'h55, 1, 7);
      run(0, 1, 1, 8'h01, 0, 25);
      for (int i = 0; i < 16; i++) begin
         w = 1'($urandom);
         r = 1'($urandom);
         b = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
         run(w, 0, 0, b, r, 0);
      end
      sel = 0;
      @(negedge clk);
      di4 = 1; n = 0; k = 0; pe = 0;
      while (k < 2 && n < 500) begin
         @(negedge clk);
         n++;
         if (n == 1) di4 = 0;
         if (e4 && !pe) k++;
         pe = e4;
      end
      chk("abort_reach", k, 2);
      reset = 0;
      @(negedge clk);
      chk("abort_lcde", int'(e4), 0);
      chk("abort_busy", int'(busy4), 0);
      chk("abort_ready", int'(ready4), 0);
      chk("abort_dat", int'(dat4), 0);
      reset = 1;
      @(negedge clk);
      run(0, 1, 0, 8'h00, 0, 0);
      chk("ready8_low", int'(ready8), 0);
      run(1, 0, 0, 8'hA5, 1, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
